icache_miss_ctrl: RTL and testbench
===================================

// Module: icache_miss_ctrl
// PURPOSE
//  Fetch-side front end and miss handler for the 2-way word-line icache.
//  Sits between the IF stage and the icache/instruction-memory port.
//  - Cache hit: returns the instruction combinationally.
//  - Miss: issues one word read to memory, writes the word into the cache, and forwards it to IF.
// PARAMETERS
//  ADDR_W       32            fetch/memory address width
//  UNC_BASE     32'hF000_0000 base of the uncached region (fetched from memory, never written to the cache)
//  UNC_MASK     32'hF000_0000 region match: (if_addr & UNC_MASK) == UNC_BASE
// PORTS
//  clk        in   1   clock
//  rst        in   1   synchronous, active-high reset
//  if_req     in   1   IF requests instruction at if_addr; holds if_addr stable until if_valid/if_flush
//  if_addr    in   32  fetch PC, word aligned
//  if_flush   in   1   redirect; cancels the current fetch
//  if_valid   out  1   instruction/error returned this cycle
//  if_inst    out  32  instruction (0 when if_err)
//  if_err     out  1   bus error on this fetch (qualifies if_valid)
//  if_stall   out  1   miss in progress; IF must hold
//  c_r_en     out  1   cache lookup enable
//  c_r_addr   out  32  cache lookup address (= if_addr)
//  c_hit      in   1   cache hit, same cycle
//  c_r_data   in   32  cache data, same cycle
//  c_w_en     out  1   cache write, one-cycle pulse
//  c_w_addr   out  32  cache write address
//  c_w_data   out  32  cache write data
//  mem_req    out  1   memory read request
//  mem_addr   out  32  memory address
//  mem_gnt    in   1   request accepted when mem_req & mem_gnt
//  mem_rvalid in   1   read response valid
//  mem_rdata  in   32  read response data
//  mem_err    in   1   response error, qualifies mem_rvalid
// BEHAVIOUR
//  Reset: state=IDLE, miss_addr=0, cancel=0.
//    All outputs 0 (if_valid, if_err, if_stall, c_r_en, c_w_en, mem_req).
//  Output sources:
//    mem_addr=miss_addr; c_w_addr=miss_addr; c_w_data=mem_rdata.
//    c_r_addr=if_addr; if_inst=0 when if_valid=0.
//  States: IDLE, REQ, WAIT.
//  IDLE: c_r_en=if_req & ~if_flush & ~unc(if_addr).
//    - Hit: if_valid=1, if_inst=c_r_data, same cycle (0-cycle latency).
//    - Miss or uncached: latch miss_addr=if_addr, go to REQ.
//    - if_flush=1: no lookup, no if_valid, no miss launched.
//  REQ: mem_req=1 and if_stall=1; mem_req is held until mem_gnt.
//    - On mem_gnt: go to WAIT.
//    - if_flush before grant: drop mem_req, go to IDLE; no memory transaction occurs.
//  WAIT: mem_req=0, if_stall=~cancel.
//    - if_flush sets cancel; the response is still awaited. There is 1 outstanding read max.
//    - On mem_rvalid & ~mem_err:
//        c_w_en=1 unless the address is uncached.
//        if_valid=~cancel, if_inst=mem_rdata.
//        Return to IDLE and clear cancel.
//    - On mem_rvalid & mem_err: no cache write; if_valid=~cancel, if_err=~cancel, if_inst=0; go to IDLE.
//    - if_flush in the same cycle as mem_rvalid: cache is written, if_valid suppressed.
//  Miss penalty: lookup cycle + grant wait + response wait.
//    Minimum 2 cycles (gnt in REQ's first cycle, rvalid the next).
//  mem_rvalid outside WAIT is ignored.
//    This covers a late response after a mid-miss reset.
//    The memory side must not hold a response across rst.
//  Reset mid-miss: IDLE next cycle, mem_req deasserted, no cache write.
// CONFIGURATION
//  ICACHE_PERF_EN defined: three 32-bit counters, saturating at 32'hFFFF_FFFF and cleared by rst:
//    - perf_hit: +1 per IDLE hit returned.
//    - perf_miss: +1 per IDLE->REQ.
//    - perf_stall: +1 per cycle in REQ|WAIT.
//    Exposed as output ports of the same names.
//  ICACHE_PERF_EN undefined: no counters and no perf ports; behaviour otherwise identical.
// STRUCTURE
//  icache_pkg / define.v:
//    - state encodings S_IDLE=2'd0, S_REQ=2'd1, S_WAIT=2'd2
//    - ADDR_W
//    - the unc() region test macro
//  Sub-module icache_perf_cnt (saturating counter bank) under ICACHE_PERF_EN.
//  FSM + datapath stays in this module.
// TESTING
//  1. Hit: preload 0x100=0x00000013.
//     if_req @0x100 -> if_valid=1, if_inst=0x00000013 same cycle, mem_req never set.
//  2. Miss: if_req @0x200, gnt after 3 cycles, rvalid 2 cycles later with 0xDEADBEEF.
//     -> if_stall high throughout; c_w_en 1 cycle (0x200, 0xDEADBEEF); if_valid with same data.
//     -> Re-fetch of 0x200 hits.
//  3. Flush in WAIT: miss @0x300, if_flush after gnt, rvalid 0x1111.
//     -> c_w_en=1, if_valid=0; a new if_req @0x300 hits 0x1111.
//  4. Bus error: miss @0x400, rvalid with mem_err=1.
//     -> if_valid=1, if_err=1, if_inst=0, c_w_en=0; re-fetch misses again.
//  5. Uncached: if_req @0xF000_0010 twice -> two memory reads, c_r_en=0, c_w_en never asserted.
//  6. rst asserted in REQ: mem_req=0 next cycle, state IDLE.
//     A stray rvalid afterwards -> no if_valid, no c_w_en.
//     With ICACHE_PERF_EN: perf counters = 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the icache miss controller.
// Optional feature macro: ICACHE_PERF_EN (performance counters).
package icache_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PERF_N = 3;
  localparam int unsigned PERF_W = 32;

  // Counter slots in the perf bank
  localparam int unsigned PERF_HIT   = 0;
  localparam int unsigned PERF_MISS  = 1;
  localparam int unsigned PERF_STALL = 2;

  localparam logic [ADDR_W-1:0] UNC_BASE = 32'hF000_0000;
  localparam logic [ADDR_W-1:0] UNC_MASK = 32'hF000_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  // True when the address falls in the uncached region
  function automatic logic unc(input logic [ADDR_W-1:0] addr);
    return (addr & UNC_MASK) == UNC_BASE;
  endfunction

endpackage

// File: rtl/icache_perf_cnt.sv
// Saturating event counter bank, present only with ICACHE_PERF_EN.
`ifdef ICACHE_PERF_EN
module icache_perf_cnt
  import icache_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PERF_N-1:0]             inc,
  output logic [PERF_N-1:0][PERF_W-1:0] cnt
);

  // Each counter steps on its event and sticks at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      for (int i = 0; i < int'(PERF_N); i++) begin
        if (inc[i] && (cnt[i] != {PERF_W{1'b1}})) begin
          cnt[i] <= cnt[i] + PERF_W'(1);
        end
      end
    end
  end

endmodule
`endif

// File: rtl/icache_miss_ctrl.sv
// Fetch front end and single-outstanding-read miss handler for the icache.
// Optional feature macro: ICACHE_PERF_EN adds perf_hit/perf_miss/perf_stall.
module icache_miss_ctrl
  import icache_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_err,
  output logic              if_stall,
  output logic              c_r_en,
  output logic [ADDR_W-1:0] c_r_addr,
  input  logic              c_hit,
  input  logic [DATA_W-1:0] c_r_data,
  output logic              c_w_en,
  output logic [ADDR_W-1:0] c_w_addr,
  output logic [DATA_W-1:0] c_w_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_err
`ifdef ICACHE_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_hit,
  output logic [PERF_W-1:0] perf_miss,
  output logic [PERF_W-1:0] perf_stall
`endif
);

  state_t            state, state_n;
  logic [ADDR_W-1:0] miss_addr, miss_addr_n;
  logic              cancel, cancel_n;
  logic              lookup;
  logic              hit_evt, miss_evt;
  logic              resp_valid;

  assign c_r_addr = if_addr;
  assign mem_addr = miss_addr;
  assign c_w_addr = miss_addr;
  assign c_w_data = mem_rdata;

  // A fetch in IDLE is looked up only if it is live and cacheable
  assign lookup = if_req & ~if_flush & ~unc(if_addr);

  // State, latched miss address and cancel flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      miss_addr <= '0;
      cancel    <= 1'b0;
    end else begin
      state     <= state_n;
      miss_addr <= miss_addr_n;
      cancel    <= cancel_n;
    end
  end

  // Next state and combinational fetch/cache/memory outputs; all quiet in reset
  always_comb begin
    state_n     = state;
    miss_addr_n = miss_addr;
    cancel_n    = cancel;
    c_r_en      = 1'b0;
    if_valid    = 1'b0;
    if_inst     = '0;
    if_err      = 1'b0;
    if_stall    = 1'b0;
    mem_req     = 1'b0;
    c_w_en      = 1'b0;
    hit_evt     = 1'b0;
    miss_evt    = 1'b0;
    resp_valid  = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          c_r_en = lookup;
          if (if_req && !if_flush) begin
            if (lookup && c_hit) begin
              if_valid = 1'b1;
              if_inst  = c_r_data;
              hit_evt  = 1'b1;
            end else begin
              miss_addr_n = if_addr;
              state_n     = S_REQ;
              miss_evt    = 1'b1;
            end
          end
        end
        S_REQ: begin
          if_stall = 1'b1;
          // A flush before grant abandons the miss with no bus traffic
          if (if_flush) begin
            state_n = S_IDLE;
          end else begin
            mem_req = 1'b1;
            if (mem_gnt) begin
              state_n = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if_stall = ~cancel;
          if (mem_rvalid) begin
            // The fill still lands in the cache even if the fetch was redirected
            resp_valid = ~(cancel | if_flush);
            c_w_en     = ~mem_err & ~unc(miss_addr);
            if_valid   = resp_valid;
            if_err     = resp_valid & mem_err;
            if_inst    = (resp_valid && !mem_err) ? mem_rdata : '0;
            state_n    = S_IDLE;
            cancel_n   = 1'b0;
          end else if (if_flush) begin
            cancel_n = 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  logic [PERF_N-1:0]             perf_inc;
  logic [PERF_N-1:0][PERF_W-1:0] perf_cnt;

  // Event strobes for the counter bank
  always_comb begin
    perf_inc             = '0;
    perf_inc[PERF_HIT]   = hit_evt;
    perf_inc[PERF_MISS]  = miss_evt;
    perf_inc[PERF_STALL] = ~rst & ((state == S_REQ) | (state == S_WAIT));
  end

  icache_perf_cnt u_perf (
    .clk (clk),
    .rst (rst),
    .inc (perf_inc),
    .cnt (perf_cnt)
  );

  assign perf_hit   = perf_cnt[PERF_HIT];
  assign perf_miss  = perf_cnt[PERF_MISS];
  assign perf_stall = perf_cnt[PERF_STALL];
`else
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Self-checking bench for icache_miss_ctrl: directed scenarios plus random fetches
// against a transaction-level model of cache contents and fetch outcomes.
module tb_icache_miss_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_valid;
  logic [31:0] if_inst;
  logic        if_err;
  logic        if_stall;
  logic        c_r_en;
  logic [31:0] c_r_addr;
  logic        c_hit;
  logic [31:0] c_r_data;
  logic        c_w_en;
  logic [31:0] c_w_addr;
  logic [31:0] c_w_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
  logic [31:0] perf_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_hits   = 0;
  int exp_misses = 0;
  int exp_stalls = 0;

  // Storage held by the cache stub (written by the DUT) and the model's view of it
  logic [31:0] cache_arr [logic [31:0]];
  logic [31:0] ref_cache [logic [31:0]];

  always #5 clk = ~clk;

  icache_miss_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_valid   (if_valid),
    .if_inst    (if_inst),
    .if_err     (if_err),
    .if_stall   (if_stall),
    .c_r_en     (c_r_en),
    .c_r_addr   (c_r_addr),
    .c_hit      (c_hit),
    .c_r_data   (c_r_data),
    .c_w_en     (c_w_en),
    .c_w_addr   (c_w_addr),
    .c_w_data   (c_w_data),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_err    (mem_err)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit   (perf_hit),
    .perf_miss  (perf_miss),
    .perf_stall (perf_stall)
`endif
  );

  // Cache stub storage update
  always @(posedge clk) begin
    if (c_w_en) cache_arr[c_w_addr] = c_w_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lookup(input logic [31:0] addr);
    if_addr = addr;
    c_hit   = cache_arr.exists(addr);
    c_r_data = c_hit ? cache_arr[addr] : 32'hBAD0_BAD0;
  endtask

  function automatic bit is_unc(input logic [31:0] addr);
    return (addr & 32'hF000_0000) == 32'hF000_0000;
  endfunction

  task automatic check_perf(input string tag);
`ifdef ICACHE_PERF_EN
    check({tag, "_perf_hit"},   perf_hit,   32'(exp_hits));
    check({tag, "_perf_miss"},  perf_miss,  32'(exp_misses));
    check({tag, "_perf_stall"}, perf_stall, 32'(exp_stalls));
`else
    n_tests = n_tests + 0;
`endif
  endtask

  // One complete fetch. fmode: 0 none, 1 flush in REQ instead of grant, 2 flush in first WAIT cycle
  task automatic fetch(input logic [31:0] addr, input int gnt_dly, input int rv_dly,
                       input bit err, input logic [31:0] rdata, input int fmode);
    bit u, exp_hit, cancel_m, flush_now, exp_we, exp_valid;
    u = is_unc(addr);
    exp_hit = !u && ref_cache.exists(addr);
    if_req = 1'b1; if_flush = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_err = 1'b0;
    set_lookup(addr);
    #1;
    check("lookup_en", 32'(c_r_en), 32'(!u));
    check("lookup_addr", c_r_addr, addr);
    if (exp_hit) begin
      check("hit_valid", 32'(if_valid), 32'd1);
      check("hit_inst", if_inst, ref_cache[addr]);
      check("hit_noreq", 32'(mem_req), 32'd0);
      check("hit_nostall", 32'(if_stall), 32'd0);
      exp_hits++;
      tick();
      if_req = 1'b0;
      return;
    end
    check("miss_valid", 32'(if_valid), 32'd0);
    exp_misses++;
    tick();
    for (int g = 0; g <= gnt_dly; g++) begin
      check("req_stall", 32'(if_stall), 32'd1);
      check("req_addr", mem_addr, addr);
      check("req_no_wr", 32'(c_w_en), 32'd0);
      if (fmode == 1 && g == gnt_dly) begin
        if_flush = 1'b1; if_req = 1'b0;
        #1;
        check("req_flush_drop", 32'(mem_req), 32'd0);
        exp_stalls++;
        tick();
        if_flush = 1'b0;
        #1;
        check("flush_idle_req", 32'(mem_req), 32'd0);
        check("flush_idle_stall", 32'(if_stall), 32'd0);
        return;
      end
      check("req_hold", 32'(mem_req), 32'd1);
      if (g == gnt_dly) mem_gnt = 1'b1;
      exp_stalls++;
      tick();
    end
    mem_gnt = 1'b0;
    cancel_m = 1'b0;
    for (int w = 0; w <= rv_dly; w++) begin
      flush_now = (fmode == 2 && w == 0);
      if_flush = flush_now;
      if (flush_now) if_req = 1'b0;
      if (w == rv_dly) begin
        mem_rvalid = 1'b1; mem_rdata = rdata; mem_err = err;
      end
      #1;
      check("wait_noreq", 32'(mem_req), 32'd0);
      check("wait_stall", 32'(if_stall), 32'(!cancel_m));
      if (w == rv_dly) begin
        exp_we    = !err && !u;
        exp_valid = !(cancel_m || flush_now);
        check("resp_wen", 32'(c_w_en), 32'(exp_we));
        if (exp_we) begin
          check("resp_waddr", c_w_addr, addr);
          check("resp_wdata", c_w_data, rdata);
          ref_cache[addr] = rdata;
        end
        check("resp_valid", 32'(if_valid), 32'(exp_valid));
        check("resp_err", 32'(if_err), 32'(err && exp_valid));
        check("resp_inst", if_inst, (exp_valid && !err) ? rdata : 32'd0);
      end else begin
        check("wait_novalid", 32'(if_valid), 32'd0);
        check("wait_now", 32'(c_w_en), 32'd0);
      end
      exp_stalls++;
      tick();
      if (flush_now) cancel_m = 1'b1;
    end
    mem_rvalid = 1'b0; mem_err = 1'b0; if_flush = 1'b0; if_req = 1'b0;
    #1;
    check("end_idle_stall", 32'(if_stall), 32'd0);
    check("end_idle_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    logic [31:0] pool [10];
    logic [31:0] a;
    int fm;

    rst = 1'b1; if_req = 1'b1; if_addr = 32'h100; if_flush = 1'b0;
    c_hit = 1'b1; c_r_data = 32'h13; mem_gnt = 1'b1; mem_rvalid = 1'b1;
    mem_rdata = 32'h5555_5555; mem_err = 1'b0;
    cache_arr[32'h100] = 32'h0000_0013;
    ref_cache[32'h100] = 32'h0000_0013;
    tick();
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_stall", 32'(if_stall), 32'd0);
    check("rst_c_r_en", 32'(c_r_en), 32'd0);
    check("rst_c_w_en", 32'(c_w_en), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    tick();
    rst = 1'b0; if_req = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    check_perf("post_rst");

    // 1: hit
    fetch(32'h100, 0, 0, 1'b0, 32'h0, 0);
    // 2: miss with delayed grant and response, then a hit
    fetch(32'h200, 3, 2, 1'b0, 32'hDEAD_BEEF, 0);
    fetch(32'h200, 0, 0, 1'b0, 32'h0, 0);
    // 3: flush during WAIT, fill still lands
    fetch(32'h300, 0, 1, 1'b0, 32'h0000_1111, 2);
    fetch(32'h300, 0, 0, 1'b0, 32'h0, 0);
    // 4: bus error, refetch misses again
    fetch(32'h400, 1, 0, 1'b1, 32'h7777_7777, 0);
    fetch(32'h400, 0, 0, 1'b0, 32'h0000_4444, 0);
    // 5: uncached twice
    fetch(32'hF000_0010, 0, 0, 1'b0, 32'hAAAA_0001, 0);
    fetch(32'hF000_0010, 1, 1, 1'b0, 32'hAAAA_0002, 0);
    // Flush before grant
    fetch(32'h500, 2, 0, 1'b0, 32'h0, 1);
    check_perf("directed");

    // 6: reset while in REQ, then a stray response
    if_req = 1'b1; set_lookup(32'h600);
    #1;
    tick();
    check("rstreq_req", 32'(mem_req), 32'd1);
    rst = 1'b1; if_req = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rstreq_req_off", 32'(mem_req), 32'd0);
    check("rstreq_stall_off", 32'(if_stall), 32'd0);
    exp_hits = 0; exp_misses = 0; exp_stalls = 0;
    check_perf("rstreq");
    mem_rvalid = 1'b1; mem_rdata = 32'h6666_6666;
    #1;
    check("stray_valid", 32'(if_valid), 32'd0);
    check("stray_wen", 32'(c_w_en), 32'd0);
    tick();
    mem_rvalid = 1'b0;
    fetch(32'h600, 0, 0, 1'b0, 32'h0000_6000, 0);

    // Random fetches over a small address pool
    for (int k = 0; k < 8; k++) pool[k] = 32'h1000 + 32'(k * 4);
    pool[8] = 32'hF000_0020;
    pool[9] = 32'hF000_0040;
    for (int it = 0; it < 80; it++) begin
      a  = pool[$urandom_range(0, 9)];
      fm = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
      fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 7) == 0), $urandom, fm);
      if ($urandom_range(0, 3) == 0) begin
        mem_rvalid = 1'b1; mem_rdata = $urandom; mem_err = 1'($urandom_range(0, 1));
        #1;
        check("idle_stray_valid", 32'(if_valid), 32'd0);
        check("idle_stray_wen", 32'(c_w_en), 32'd0);
        check("idle_no_lookup", 32'(c_r_en), 32'd0);
        tick();
        mem_rvalid = 1'b0; mem_err = 1'b0;
      end
    end
    check_perf("random");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
